// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values, default amount width, dispenser FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vend_pkg;

  localparam int COIN5_VAL  = 5;
  localparam int COIN10_VAL = 10;

  // Default width of amount / dispensed fields across the vending blocks.
  localparam int DEF_COIN_W = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    EJECT10 = 3'd2,
    EJECT5  = 3'd3,
    GAP     = 3'd4,
    FINISH  = 3'd5
  } disp_state_t;

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter that times the eject strobe and the inter-coin gap.
// Latency: expired rises load_val cycles after the load edge (load_val=0 -> expired next cycle).
// Backpressure: none; load always wins over counting.
//   clk, reset : clock, synchronous active-high reset
//   load       : restart the count from load_val
//   load_val   : cycles to run after the load cycle
//   expired    : count has reached zero
module pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = (r_cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-return unit: splits a change request into 10/5-rupee coins (largest first) and strobes the hoppers.
// Latency: first strobe 2 cycles after accept; 7 cycles per coin; done 2 cycles after the last gap.
// Backpressure: req_ready is high only in IDLE; one request in flight at a time.
//   req_valid/req_ready/req_amount : change request handshake
//   eject_10/eject_5               : hopper strobes, PULSE_CYCLES high then GAP_CYCLES low
//   done/dispensed/shortfall       : completion pulse and held result of the last request
//   refill_valid/refill_10/refill_5: saturating hopper top-up, honoured in IDLE only
//   cnt10/cnt5/busy                : live inventory and activity status
module change_dispenser
  import vend_pkg::*;
#(
  parameter int COIN_W       = DEF_COIN_W,
  parameter int INV_W        = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int INIT_CNT10   = 20,
  parameter int INIT_CNT5    = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [COIN_W-1:0] req_amount,
  output logic              eject_10,
  output logic              eject_5,
  output logic              done,
  output logic [COIN_W-1:0] dispensed,
  output logic              shortfall,
  input  logic              refill_valid,
  input  logic [INV_W-1:0]  refill_10,
  input  logic [INV_W-1:0]  refill_5,
  output logic [INV_W-1:0]  cnt10,
  output logic [INV_W-1:0]  cnt5,
  output logic              busy
);

  localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  disp_state_t       r_state;
  logic              r_req_ready;
  logic              r_busy;
  logic              r_eject_10;
  logic              r_eject_5;
  logic              r_done;
  logic              r_shortfall;
  logic [COIN_W-1:0] r_remaining;
  logic [COIN_W-1:0] r_dispensed;
  logic [INV_W-1:0]  r_cnt10;
  logic [INV_W-1:0]  r_cnt5;

  logic              w_take10;
  logic              w_take5;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_expired;
  logic [INV_W:0]    w_sum10;
  logic [INV_W:0]    w_sum5;
  logic [INV_W-1:0]  w_fill10;
  logic [INV_W-1:0]  w_fill5;

  // Coin choice only ever subtracts what the guard proves is available.
  assign w_take10 = (r_remaining >= COIN_W'(COIN10_VAL)) && (r_cnt10 != '0);
  assign w_take5  = (r_remaining >= COIN_W'(COIN5_VAL))  && (r_cnt5  != '0);

  // One extra bit catches the carry so the counters clamp at all-ones.
  assign w_sum10  = {1'b0, r_cnt10} + {1'b0, refill_10};
  assign w_sum5   = {1'b0, r_cnt5}  + {1'b0, refill_5};
  assign w_fill10 = w_sum10[INV_W] ? {INV_W{1'b1}} : w_sum10[INV_W-1:0];
  assign w_fill5  = w_sum5[INV_W]  ? {INV_W{1'b1}} : w_sum5[INV_W-1:0];

  // Timer is reloaded on the edge that enters EJECT* or GAP; the loaded value
  // is one less than the duration because the entry cycle itself counts.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      SELECT: begin
        if (w_take10 || w_take5) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(PULSE_CYCLES - 1);
        end
      end
      EJECT10, EJECT5: begin
        if (w_expired) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(GAP_CYCLES - 1);
        end
      end
      default: ;
    endcase
  end

  pulse_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .expired  (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_eject_10  <= 1'b0;
      r_eject_5   <= 1'b0;
      r_done      <= 1'b0;
      r_shortfall <= 1'b0;
      r_remaining <= '0;
      r_dispensed <= '0;
      r_cnt10     <= INV_W'(INIT_CNT10);
      r_cnt5      <= INV_W'(INIT_CNT5);
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (refill_valid) begin
            r_cnt10 <= w_fill10;
            r_cnt5  <= w_fill5;
          end
          if (req_valid && r_req_ready) begin
            r_remaining <= req_amount;
            r_dispensed <= '0;
            r_shortfall <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= SELECT;
          end
        end
        SELECT: begin
          // Inventory and totals are booked as the strobe rises.
          if (w_take10) begin
            r_state     <= EJECT10;
            r_eject_10  <= 1'b1;
            r_cnt10     <= r_cnt10 - 1'b1;
            r_remaining <= r_remaining - COIN_W'(COIN10_VAL);
            r_dispensed <= r_dispensed + COIN_W'(COIN10_VAL);
          end else if (w_take5) begin
            r_state     <= EJECT5;
            r_eject_5   <= 1'b1;
            r_cnt5      <= r_cnt5 - 1'b1;
            r_remaining <= r_remaining - COIN_W'(COIN5_VAL);
            r_dispensed <= r_dispensed + COIN_W'(COIN5_VAL);
          end else begin
            r_state     <= FINISH;
            r_done      <= 1'b1;
            r_shortfall <= (r_remaining != '0);
          end
        end
        EJECT10, EJECT5: begin
          if (w_expired) begin
            r_eject_10 <= 1'b0;
            r_eject_5  <= 1'b0;
            r_state    <= GAP;
          end
        end
        GAP: begin
          if (w_expired) begin
            r_state <= SELECT;
          end
        end
        FINISH: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign eject_10  = r_eject_10;
  assign eject_5   = r_eject_5;
  assign done      = r_done;
  assign dispensed = r_dispensed;
  assign shortfall = r_shortfall;
  assign cnt10     = r_cnt10;
  assign cnt5      = r_cnt5;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed, table-driven bench for change_dispenser with default parameters.
// Cycle numbering: the request is presented in cycle 0 and accepted on the edge ending it.
// Outputs are sampled on the falling edge.
module tb_change_dispenser;

  localparam int PULSE = 4;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_amount;
  logic       eject_10;
  logic       eject_5;
  logic       done;
  logic [4:0] dispensed;
  logic       shortfall;
  logic       refill_valid;
  logic [7:0] refill_10;
  logic [7:0] refill_5;
  logic [7:0] cnt10;
  logic [7:0] cnt5;
  logic       busy;

  change_dispenser dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_amount   (req_amount),
    .eject_10     (eject_10),
    .eject_5      (eject_5),
    .done         (done),
    .dispensed    (dispensed),
    .shortfall    (shortfall),
    .refill_valid (refill_valid),
    .refill_10    (refill_10),
    .refill_5     (refill_5),
    .cnt10        (cnt10),
    .cnt5         (cnt5),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // amt, refill-with-accept (rv,r10,r5), refill-while-busy flag,
  // expected first strobe cycles, pulse counts, done cycle, result, inventory after.
  typedef struct {
    int amt; int rv; int r10; int r5; int brf;
    int f10; int f5; int n10; int n5; int dcyc;
    int disp; int shrt; int c10; int c5;
  } vec_t;

  vec_t tbl[19];

  // Observations from the last request.
  int o_first10, o_first5, o_n10, o_n5, o_hi10, o_hi5;
  int o_both, o_notbusy, o_done, o_disp, o_short;
  int o_ready, o_cnt10, o_cnt5, o_disp_hold, o_short_hold;

  task automatic run_req(input logic [4:0] amt, input logic rv, input logic [7:0] r10,
                         input logic [7:0] r5, input logic brf);
    logic p10, p5;
    o_first10 = 0; o_first5 = 0; o_n10 = 0; o_n5 = 0; o_hi10 = 0; o_hi5 = 0;
    o_both = 0; o_notbusy = 0; o_done = 0; o_disp = -1; o_short = -1;
    p10 = 1'b0; p5 = 1'b0;
    req_amount = amt; req_valid = 1'b1;
    refill_valid = rv; refill_10 = r10; refill_5 = r5;
    for (int c = 1; c <= 120 && o_done == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid    = 1'b0;
        refill_valid = brf;
      end
      if (eject_10) begin
        o_hi10++;
        if (!p10) begin
          o_n10++;
          if (o_first10 == 0) o_first10 = c;
        end
      end
      if (eject_5) begin
        o_hi5++;
        if (!p5) begin
          o_n5++;
          if (o_first5 == 0) o_first5 = c;
        end
      end
      if (eject_10 && eject_5) o_both++;
      if (!busy) o_notbusy++;
      if (done) begin
        o_done = c; o_disp = int'(dispensed); o_short = int'(shortfall);
        refill_valid = 1'b0;
      end
      p10 = eject_10; p5 = eject_5;
    end
    refill_valid = 1'b0;
    @(negedge clk);
    o_ready = int'(req_ready); o_cnt10 = int'(cnt10); o_cnt5 = int'(cnt5);
    o_disp_hold = int'(dispensed); o_short_hold = int'(shortfall);
  endtask

  initial begin
    int dn;
    reset = 1'b1; req_valid = 1'b0; req_amount = '0;
    refill_valid = 1'b0; refill_10 = '0; refill_5 = '0;

    tbl[0]  = '{15, 0, 0,   0, 0,  2, 9, 1, 1, 16, 15, 0, 19, 19};
    tbl[1]  = '{ 0, 0, 0,   0, 0,  0, 0, 0, 0,  2,  0, 0, 19, 19};
    tbl[2]  = '{ 7, 0, 0,   0, 0,  0, 2, 0, 1,  9,  5, 1, 19, 18};
    tbl[3]  = '{30, 0, 0,   0, 0,  2, 0, 3, 0, 23, 30, 0, 16, 18};
    tbl[4]  = '{30, 0, 0,   0, 0,  2, 0, 3, 0, 23, 30, 0, 13, 18};
    tbl[5]  = '{30, 0, 0,   0, 0,  2, 0, 3, 0, 23, 30, 0, 10, 18};
    tbl[6]  = '{30, 0, 0,   0, 0,  2, 0, 3, 0, 23, 30, 0,  7, 18};
    tbl[7]  = '{30, 0, 0,   0, 0,  2, 0, 3, 0, 23, 30, 0,  4, 18};
    tbl[8]  = '{30, 0, 0,   0, 0,  2, 0, 3, 0, 23, 30, 0,  1, 18};
    tbl[9]  = '{10, 0, 0,   0, 0,  2, 0, 1, 0,  9, 10, 0,  0, 18};
    tbl[10] = '{20, 0, 0,   0, 0,  0, 2, 0, 4, 30, 20, 0,  0, 14};
    tbl[11] = '{25, 0, 0,   0, 0,  0, 2, 0, 5, 37, 25, 0,  0,  9};
    tbl[12] = '{25, 0, 0,   0, 0,  0, 2, 0, 5, 37, 25, 0,  0,  4};
    tbl[13] = '{15, 0, 0,   0, 0,  0, 2, 0, 3, 23, 15, 0,  0,  1};
    tbl[14] = '{15, 0, 0,   0, 0,  0, 2, 0, 1,  9,  5, 1,  0,  0};
    tbl[15] = '{ 5, 0, 0,   0, 0,  0, 0, 0, 0,  2,  0, 1,  0,  0};
    tbl[16] = '{10, 1, 1,   0, 0,  2, 0, 1, 0,  9, 10, 0,  0,  0};
    tbl[17] = '{ 0, 1, 3, 250, 0,  0, 0, 0, 0,  2,  0, 0,  3, 250};
    tbl[18] = '{10, 0, 7,   5, 1,  2, 0, 1, 0,  9, 10, 0,  2, 250};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset req_ready", int'(req_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset eject_10", int'(eject_10), 0);
    chk("reset eject_5", int'(eject_5), 0);
    chk("reset done", int'(done), 0);
    chk("reset shortfall", int'(shortfall), 0);
    chk("reset dispensed", int'(dispensed), 0);
    chk("reset cnt10", int'(cnt10), 20);
    chk("reset cnt5", int'(cnt5), 20);

    // Reset in the middle of a 10-rupee strobe
    dn = 0;
    req_amount = 5'd10; req_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (done) dn++;
      if (c == 3) begin
        chk("abort eject_10 before reset", int'(eject_10), 1);
        reset = 1'b1;
      end
      if (c == 4) begin
        chk("abort eject_10 low after reset edge", int'(eject_10), 0);
        chk("abort busy low after reset edge", int'(busy), 0);
        reset = 1'b0;
      end
    end
    @(negedge clk);
    chk("abort req_ready after reset", int'(req_ready), 1);
    chk("abort cnt10 reloaded", int'(cnt10), 20);
    chk("abort cnt5 reloaded", int'(cnt5), 20);
    for (int c = 0; c < 8; c++) begin
      if (done || eject_10 || eject_5) dn++;
      @(negedge clk);
    end
    chk("abort no done or strobe", dn, 0);

    // Table of requests
    for (int i = 0; i < 19; i++) begin
      run_req(5'(tbl[i].amt), 1'(tbl[i].rv), 8'(tbl[i].r10), 8'(tbl[i].r5), 1'(tbl[i].brf));
      chk($sformatf("row%0d done_cycle", i), o_done, tbl[i].dcyc);
      chk($sformatf("row%0d dispensed", i), o_disp, tbl[i].disp);
      chk($sformatf("row%0d shortfall", i), o_short, tbl[i].shrt);
      chk($sformatf("row%0d dispensed_held", i), o_disp_hold, tbl[i].disp);
      chk($sformatf("row%0d shortfall_held", i), o_short_hold, tbl[i].shrt);
      chk($sformatf("row%0d cnt10", i), o_cnt10, tbl[i].c10);
      chk($sformatf("row%0d cnt5", i), o_cnt5, tbl[i].c5);
      chk($sformatf("row%0d n_eject10", i), o_n10, tbl[i].n10);
      chk($sformatf("row%0d n_eject5", i), o_n5, tbl[i].n5);
      chk($sformatf("row%0d first_eject10", i), o_first10, tbl[i].f10);
      chk($sformatf("row%0d first_eject5", i), o_first5, tbl[i].f5);
      chk($sformatf("row%0d eject10_high_cycles", i), o_hi10, tbl[i].n10 * PULSE);
      chk($sformatf("row%0d eject5_high_cycles", i), o_hi5, tbl[i].n5 * PULSE);
      chk($sformatf("row%0d both_strobes", i), o_both, 0);
      chk($sformatf("row%0d busy_dropped", i), o_notbusy, 0);
      chk($sformatf("row%0d ready_after", i), o_ready, 1);
    end

    // Idle refill without a request: both counters clamp (2+254, 250+10)
    refill_valid = 1'b1; refill_10 = 8'd254; refill_5 = 8'd10;
    @(negedge clk);
    refill_valid = 1'b0;
    chk("refill sat cnt10", int'(cnt10), 255);
    chk("refill sat cnt5", int'(cnt5), 255);
    chk("refill sat busy", int'(busy), 0);
    refill_valid = 1'b1; refill_10 = 8'd1; refill_5 = 8'd0;
    @(negedge clk);
    refill_valid = 1'b0;
    chk("refill held at max cnt10", int'(cnt10), 255);
    chk("refill zero add cnt5", int'(cnt5), 255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Coin-return unit that sits downstream of the vending controller.
- Accepts a change-amount request over a valid/ready handshake and breaks it into 10-rupee and 5-rupee coins, largest first.
- Drives one hopper-eject strobe per coin with a fixed pulse width and inter-coin gap.
- Tracks per-hopper inventory and reports completion, the amount actually dispensed, and any shortfall.

Parameters:
- COIN_W, 5, width of amount and dispensed fields.
- INV_W, 8, width of each hopper inventory counter.
- PULSE_CYCLES, 4, eject strobe high time in cycles (>=1).
- GAP_CYCLES, 2, mandatory low time after each strobe (>=1).
- INIT_CNT10, 20, 10-rupee hopper count after reset.
- INIT_CNT5, 20, 5-rupee hopper count after reset.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  change request present
- req_ready  output  1  block idle, can accept a request
- req_amount  input  COIN_W  change to return, in rupees
- eject_10  output  1  10-rupee hopper strobe
- eject_5  output  1  5-rupee hopper strobe
- done  output  1  one-cycle completion pulse
- dispensed  output  COIN_W  total rupees ejected for the last request
- shortfall  output  1  last request not fully paid, valid with done and held
- refill_valid  input  1  add coins to hoppers
- refill_10  input  INV_W  10-rupee coins added
- refill_5  input  INV_W  5-rupee coins added
- cnt10  output  INV_W  current 10-rupee inventory
- cnt5  output  INV_W  current 5-rupee inventory
- busy  output  1  request in progress

Behaviour:
- Reset state:
  - State returns to IDLE.
  - eject_10, eject_5, done, shortfall and busy are 0; dispensed is 0.
  - cnt10 = INIT_CNT10 and cnt5 = INIT_CNT5.
  - req_ready is 1 from the first cycle after reset deasserts.
- Reset asserted mid-request:
  - Aborts the request; strobes go low at the same edge.
  - No done pulse is produced; inventory reloads to the INIT values.
- FSM states:
  - IDLE: req_ready=1, busy=0. On req_valid && req_ready at edge T, latch remaining=req_amount, clear dispensed and shortfall, go to SELECT.
  - SELECT, one cycle: if remaining>=10 && cnt10>0, go to EJECT10. Else if remaining>=5 && cnt5>0, go to EJECT5. Else go to FINISH.
  - EJECT10 / EJECT5: the strobe is high for exactly PULSE_CYCLES cycles. On the first cycle, decrement the hopper count, subtract the coin value from remaining, and add it to dispensed. Then go to GAP.
  - GAP: both strobes low for GAP_CYCLES cycles, then return to SELECT.
  - FINISH, one cycle: done=1, shortfall=(remaining!=0), then go to IDLE.
- busy=1 in every state except IDLE.
- eject_10 and eject_5 are never high together; all outputs are registered.
- Latency:
  - First strobe rises in cycle T+2.
  - A request with no coins to eject pulses done in cycle T+2.
  - Each coin costs 1 + PULSE_CYCLES + GAP_CYCLES cycles.
- Non-multiple-of-5 residue (amount mod 5) cannot be paid. It remains in remaining and produces shortfall=1.
- dispensed and shortfall hold their values until the next accepted request.
- Refill:
  - Applied only in IDLE. Each counter adds with saturation at 2^INV_W-1.
  - refill_valid outside IDLE is ignored.
  - A refill and an accepted request in the same IDLE cycle are both taken; the refill is visible to the first SELECT.
- Arithmetic: remaining and dispensed are COIN_W bits wide; remaining never underflows because SELECT guards every subtraction.

Decomposition:
- Shared package vend_pkg holds:
  - COIN5_VAL=5 and COIN10_VAL=10
  - the COIN_W default
  - the dispenser state enum (IDLE, SELECT, EJECT10, EJECT5, GAP, FINISH)
- One sub-module, pulse_timer:
  - Loadable down-counter giving the strobe and gap durations.
  - Ports: load, load_val, expired.
- Everything else stays in change_dispenser.

Test Plan:
- Amount 15 with full inventory, request accepted at T:
  - eject_10 high T+2..T+5, eject_5 high T+9..T+12.
  - done at T+16 with dispensed=15, shortfall=0.
  - cnt10=19, cnt5=19 afterwards.
- INIT_CNT10=0, amount 20:
  - Four eject_5 pulses and no eject_10.
  - dispensed=20, shortfall=0, cnt5=16.
- Amount 15 with cnt10=0, cnt5=1:
  - One eject_5 pulse.
  - done with dispensed=5, shortfall=1, cnt5=0.
- Amount 0:
  - done at T+2 with no strobes, dispensed=0, shortfall=0.
- Amount 7:
  - One eject_5 pulse.
  - dispensed=5, shortfall=1.
- Amount 10 accepted at T with reset asserted at T+3:
  - eject_10 is low from T+4.
  - No done pulse; req_ready=1 after reset.
  - cnt10 reloads to 20.
- Refill:
  - With cnt5=250 in IDLE, refill_5=10 gives cnt5=255 (saturation).
  - A refill issued while busy leaves both counts unchanged.
